// File: rtl/cms_trace_stream_scheduler.sv
// cms_trace_stream_scheduler
// Buffers CMS trace items and issues them as AXI-Stream beats toward the DMA.
// Packets close on a programmable beat interval or on a WFI stop. The block
// also drives CPU back-pressure (near-full halting and arbitrary halt).
// Optional feature macro: CMS_DROP_COUNTER_EN (drop counter register; when
// undefined, drop_count is tied to 0).
module cms_trace_stream_scheduler #(
  parameter int unsigned DATA_WIDTH = 1024,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  item_valid,
  input  logic [DATA_WIDTH-1:0] item_data,
  input  logic                  wfi_stop,
  input  logic                  ctrl_wr,
  input  logic [7:0]            ctrl_addr,
  input  logic [63:0]           ctrl_wdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  halt_cpu,
  output logic [31:0]           drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
  localparam logic [CW-1:0] NearFull = CW'(DEPTH - 1);
  localparam logic [CW-1:0] HalfC    = CW'(DEPTH / 2);

  localparam logic [7:0] AddrInterval = 8'd11;
  localparam logic [7:0] AddrHaltEn   = 8'd12;
  localparam logic [7:0] AddrArbHalt  = 8'd13;

  typedef enum logic [1:0] {
    StRun,
    StFullHalt,
    StArbHalt
  } state_e;

  // Storage and state
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic                  mem_last [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [31:0]           pkt_cnt_q, pkt_cnt_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [31:0]           interval_q, interval_d;
  logic                  halt_en_q, halt_en_d;
  logic                  arb_q, arb_d;
  state_e                state_q, state_d;

  // Datapath helpers
  logic                  deq;
  logic                  room;
  logic                  flush_req;
  logic                  item_last;
  logic                  enq;
  logic [DATA_WIDTH-1:0] enq_data;
  logic                  enq_last;
  logic                  drop;

  logic unused_wdata;
  assign unused_wdata = ^ctrl_wdata[63:32];

  assign m_axis_tvalid = (count_q != '0);
  assign deq           = m_axis_tvalid & m_axis_tready;
  // A full buffer still has room if a beat leaves in the same cycle.
  assign room          = (count_q != DepthC) | deq;
  // A lone WFI only needs a flush beat when the open packet holds data.
  assign flush_req     = flush_pend_q | (wfi_stop & ~item_valid & (pkt_cnt_q != '0));
  assign item_last     = ((interval_q != '0) && (pkt_cnt_q == interval_q - 32'd1)) || wfi_stop;

  // Outputs are forced to zero while no beat is presented.
  assign m_axis_tdata  = m_axis_tvalid ? mem_data[rd_ptr_q] : '0;
  assign m_axis_tlast  = m_axis_tvalid ? mem_last[rd_ptr_q] : 1'b0;
  assign halt_cpu      = (state_q != StRun);

  // Control register next values
  always_comb begin
    interval_d = interval_q;
    halt_en_d  = halt_en_q;
    arb_d      = arb_q;
    if (ctrl_wr) begin
      if (ctrl_addr == AddrInterval) interval_d = ctrl_wdata[31:0];
      if (ctrl_addr == AddrHaltEn)   halt_en_d  = ctrl_wdata[0];
      if (ctrl_addr == AddrArbHalt)  arb_d      = ctrl_wdata[0];
    end
  end

  // Enqueue selection: a pending flush wins over a new item
  always_comb begin
    enq          = 1'b0;
    enq_data     = '0;
    enq_last     = 1'b0;
    drop         = 1'b0;
    flush_pend_d = flush_pend_q;
    pkt_cnt_d    = pkt_cnt_q;
    if (flush_req) begin
      if (room) begin
        enq          = 1'b1;
        enq_last     = 1'b1;
        flush_pend_d = 1'b0;
        pkt_cnt_d    = '0;
      end else begin
        flush_pend_d = 1'b1;
      end
      if (item_valid) drop = 1'b1;
    end else if (item_valid) begin
      if (room) begin
        enq       = 1'b1;
        enq_data  = item_data;
        enq_last  = item_last;
        pkt_cnt_d = item_last ? '0 : pkt_cnt_q + 32'd1;
      end else begin
        drop = 1'b1;
      end
    end
    if (ctrl_wr && (ctrl_addr == AddrInterval)) pkt_cnt_d = '0;
  end

  // Occupancy next value
  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Halt FSM next state, evaluated on next occupancy and next config
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (arb_d) state_d = StArbHalt;
        else if (halt_en_d && (count_d >= NearFull)) state_d = StFullHalt;
      end
      StFullHalt: begin
        if (arb_d) state_d = StArbHalt;
        else if (!halt_en_d || (count_d <= HalfC)) state_d = StRun;
      end
      StArbHalt: begin
        if (!arb_d) begin
          if (count_d < NearFull) state_d = StRun;
          else if (halt_en_d) state_d = StFullHalt;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Buffer storage; contents need no reset since outputs are gated by occupancy
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_data[wr_ptr_q] <= enq_data;
      mem_last[wr_ptr_q] <= enq_last;
    end
  end

  // Pointers, occupancy, packet tracking, config and FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pkt_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      interval_q   <= '0;
      halt_en_q    <= 1'b0;
      arb_q        <= 1'b0;
      state_q      <= StRun;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q      <= count_d;
      pkt_cnt_q    <= pkt_cnt_d;
      flush_pend_q <= flush_pend_d;
      interval_q   <= interval_d;
      halt_en_q    <= halt_en_d;
      arb_q        <= arb_d;
      state_q      <= state_d;
    end
  end

`ifdef CMS_DROP_COUNTER_EN
  logic [31:0] drop_cnt_q;

  // Saturating count of items lost to a full buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
      drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_cms_trace_stream_scheduler.sv
// Directed bench for cms_trace_stream_scheduler (DEPTH=4, 32-bit data).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cms_trace_stream_scheduler;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
`ifdef CMS_DROP_COUNTER_EN
  localparam logic [31:0] ExpDrops = 32'd2;
`else
  localparam logic [31:0] ExpDrops = 32'd0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          item_valid;
  logic [DW-1:0] item_data;
  logic          wfi_stop;
  logic          ctrl_wr;
  logic [7:0]    ctrl_addr;
  logic [63:0]   ctrl_wdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          halt_cpu;
  logic [31:0]   drop_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cms_trace_stream_scheduler #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .item_valid   (item_valid),
    .item_data    (item_data),
    .wfi_stop     (wfi_stop),
    .ctrl_wr      (ctrl_wr),
    .ctrl_addr    (ctrl_addr),
    .ctrl_wdata   (ctrl_wdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .halt_cpu     (halt_cpu),
    .drop_count   (drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] d);
    ctrl_wr    = 1'b1;
    ctrl_addr  = a;
    ctrl_wdata = d;
    step();
    ctrl_wr    = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    item_valid    = 1'b0;
    item_data     = '0;
    wfi_stop      = 1'b0;
    ctrl_wr       = 1'b0;
    ctrl_addr     = '0;
    ctrl_wdata    = '0;
    m_axis_tready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_halt", halt_cpu, 0);
    chk("rst_drops", drop_count, 0);
    rst_n = 1'b1;
    step();

    // Interval framing: 7 items, interval 3
    m_axis_tready = 1'b1;
    wr(8'd11, 64'd3);
    for (int i = 1; i <= 7; i++) begin
      item_valid = 1'b1;
      item_data  = DW'(i);
      step();
      chk("ivl_tvalid", m_axis_tvalid, 1);
      chk("ivl_tdata", m_axis_tdata, i);
      chk("ivl_tlast", m_axis_tlast, (i == 3 || i == 6) ? 1 : 0);
    end
    item_valid = 1'b0;
    step();
    chk("ivl_idle", m_axis_tvalid, 0);

    // WFI flush with interval framing off
    wr(8'd11, 64'd0);
    item_valid = 1'b1;
    item_data  = 32'hA1;
    step();
    chk("wfi_b1_data", m_axis_tdata, 32'hA1);
    chk("wfi_b1_last", m_axis_tlast, 0);
    item_data  = 32'hA2;
    step();
    chk("wfi_b2_data", m_axis_tdata, 32'hA2);
    chk("wfi_b2_last", m_axis_tlast, 0);
    item_valid = 1'b0;
    wfi_stop   = 1'b1;
    step();
    wfi_stop   = 1'b0;
    chk("wfi_flush_valid", m_axis_tvalid, 1);
    chk("wfi_flush_data", m_axis_tdata, 0);
    chk("wfi_flush_last", m_axis_tlast, 1);
    wfi_stop   = 1'b1;
    step();
    wfi_stop   = 1'b0;
    chk("wfi_lone_none", m_axis_tvalid, 0);
    step();
    chk("wfi_lone_none2", m_axis_tvalid, 0);

    // Near-full halting
    m_axis_tready = 1'b0;
    wr(8'd12, 64'd1);
    item_valid = 1'b1;
    item_data  = 32'hB1;
    step();
    chk("full_halt_occ1", halt_cpu, 0);
    item_data  = 32'hB2;
    step();
    chk("full_halt_occ2", halt_cpu, 0);
    item_data  = 32'hB3;
    step();
    chk("full_halt_occ3", halt_cpu, 1);
    chk("full_stable_data", m_axis_tdata, 32'hB1);
    item_valid    = 1'b0;
    m_axis_tready = 1'b1;
    step();
    chk("full_release", halt_cpu, 0);
    chk("full_drain_b2", m_axis_tdata, 32'hB2);
    step();
    chk("full_drain_b3", m_axis_tdata, 32'hB3);
    step();
    chk("full_drain_done", m_axis_tvalid, 0);
    chk("full_no_drops", drop_count, 0);

    // Overflow with halting disabled
    m_axis_tready = 1'b0;
    wr(8'd12, 64'd0);
    for (int i = 1; i <= 6; i++) begin
      item_valid = 1'b1;
      item_data  = 32'hC0 + DW'(i);
      step();
      chk("ovf_no_halt", halt_cpu, 0);
    end
    item_valid = 1'b0;
    chk("ovf_drops", drop_count, ExpDrops);
    chk("ovf_head", m_axis_tdata, 32'hC1);
    m_axis_tready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("ovf_drain", m_axis_tdata, 32'hC0 + i);
    end
    step();
    chk("ovf_only4", m_axis_tvalid, 0);

    // Arbitrary halt
    wr(8'd13, 64'd1);
    chk("arb_on", halt_cpu, 1);
    wr(8'd13, 64'd0);
    chk("arb_off", halt_cpu, 0);

    // Reset mid-packet: interval 2, three beats queued, packet left open
    m_axis_tready = 1'b0;
    wr(8'd11, 64'd2);
    for (int i = 1; i <= 3; i++) begin
      item_valid = 1'b1;
      item_data  = 32'hD0 + DW'(i);
      step();
    end
    item_valid = 1'b0;
    chk("mid_queued", m_axis_tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_tvalid", m_axis_tvalid, 0);
    chk("mid_async_tdata", m_axis_tdata, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_empty", m_axis_tvalid, 0);
    m_axis_tready = 1'b1;
    wr(8'd11, 64'd2);
    wfi_stop = 1'b1;
    step();
    wfi_stop = 1'b0;
    chk("post_rst_no_flush", m_axis_tvalid, 0);
    item_valid = 1'b1;
    item_data  = 32'hE1;
    step();
    chk("post_rst_e1_data", m_axis_tdata, 32'hE1);
    chk("post_rst_e1_last", m_axis_tlast, 0);
    item_data  = 32'hE2;
    step();
    chk("post_rst_e2_data", m_axis_tdata, 32'hE2);
    chk("post_rst_e2_last", m_axis_tlast, 1);
    item_valid = 1'b0;
    step();
    chk("post_rst_idle", m_axis_tvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cms_trace_stream_scheduler.md
# cms_trace_stream_scheduler

Output-side scheduler for the continuous monitoring system: buffers trace items from the CMS collection logic and issues them as AXI-Stream beats toward the DMA. It frames packets with `tlast` on a programmable beat interval or on a WFI stop. It also owns CPU back-pressure, raising `halt_cpu` when the buffer is near full (if enabled) or on an arbitrary-halt request. It is configured through the shared CMS control write port (8-bit address, 64-bit data).

## Interface
- `DATA_WIDTH`, 1024: trace item / `tdata` width (matches AXI data width).
- `DEPTH`, 4: buffer entries; power of two, ≥4.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `item_valid`  in  1  trace item present this cycle.
- `item_data`  in  DATA_WIDTH  trace item.
- `wfi_stop`  in  1  one-cycle pulse: traced program reached WFI; close the current packet.
- `ctrl_wr`  in  1  control write strobe.
- `ctrl_addr`  in  8  control address.
- `ctrl_wdata`  in  64  control write data.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  sink ready.
- `m_axis_tdata`  out  DATA_WIDTH  beat data.
- `m_axis_tlast`  out  1  last beat of packet.
- `halt_cpu`  out  1  stall request to the traced core.
- `drop_count`  out  32  items lost to a full buffer (see Configuration).

## Operation
- Control registers, written when `ctrl_wr`=1 and the address matches; other addresses are ignored:
  - addr 11, TLAST_INTERVAL: `ctrl_wdata[31:0]`, beats per packet; 0 disables interval framing.
  - addr 12, HALTING_ON_FULL_FIFO_ENABLED: `ctrl_wdata[0]`.
  - addr 13, ARBITRARY_HALT: `ctrl_wdata[0]`.
  - All reset to 0.
- Buffer: circular FIFO of DEPTH entries, each {data, last}, with an occupancy counter of width log2(DEPTH)+1.
- Enqueue: when `item_valid`=1 and occupancy<DEPTH, or occupancy=DEPTH with a dequeue in the same cycle.
- Dequeue: `tvalid`&`tready`.
- Simultaneous enqueue and dequeue leave occupancy unchanged.
- Items arriving with no room are dropped and increment `drop_count`, which saturates at 0xFFFFFFFF.
- Packet counter `pkt_cnt` (32-bit) counts enqueued beats in the open packet. Entry `last`=1 if interval≠0 and `pkt_cnt`=interval−1, or if `wfi_stop`=1 in the same cycle. A `last` entry resets `pkt_cnt` to 0; otherwise `pkt_cnt` increments.
- Writing TLAST_INTERVAL resets `pkt_cnt` to 0.
- `wfi_stop` without `item_valid`, with `pkt_cnt`>0: enqueue a flush beat, `tdata`=0 and `last`=1. If the buffer is full, the flush is held pending and enqueued on the first free cycle; a pending flush takes priority over new items.
- `wfi_stop` with `pkt_cnt`=0 and no item: no action.
- Halt FSM, `halt_cpu` = (state≠RUN):
  - RUN → ARB_HALT when ARBITRARY_HALT=1.
  - RUN → FULL_HALT when halting is enabled and next occupancy ≥ DEPTH−1.
  - FULL_HALT → RUN when occupancy ≤ DEPTH/2, or halting is disabled.
  - FULL_HALT → ARB_HALT when ARBITRARY_HALT=1.
  - ARB_HALT → RUN when ARBITRARY_HALT=0 and occupancy < DEPTH−1; otherwise → FULL_HALT if halting is enabled.
- Upstream must not assert `item_valid` while `halt_cpu`=1. If it does, the item is still accepted or dropped by the rules above.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `halt_cpu`=0, `drop_count`=0. Buffer is empty, FSM is in RUN, no flush is pending.
- Enqueue-to-`tvalid` latency is 1 cycle; with `tready` held high, the pipeline delivers one beat per cycle.
- `tdata`/`tlast` are stable while `tvalid`=1 and `tready`=0; `tvalid` never drops without a handshake.
- `halt_cpu` is registered from next-state logic. It rises at the same edge where occupancy reaches DEPTH−1, leaving one free slot as margin.
- A control write takes effect in the cycle after `ctrl_wr`.
- `rst_n` assertion mid-packet discards buffer contents and the pending flush immediately. No partial packet is emitted after release.

## Configuration
- `CMS_DROP_COUNTER_EN` defined: drop counter implemented as specified.
- `CMS_DROP_COUNTER_EN` undefined: no counter register; `drop_count` is tied to 0. Dropping behaviour is unchanged.

## Test plan
- Interval=3, `tready`=1, 7 consecutive items → beats 1–7 with `tlast` on beats 3 and 6; beat 7 has `tlast`=0.
- Interval=0, 2 items, then `wfi_stop` alone → 3 beats; the third has `tdata`=0, `tlast`=1. A second lone `wfi_stop` → no beat.
- Halting enabled, `tready`=0, DEPTH=4, items every cycle → `halt_cpu`=1 at the edge occupancy hits 3. Then `tready`=1 → `halt_cpu` falls once occupancy ≤2; no drops.
- Halting disabled, `tready`=0, 6 items → 4 buffered, `drop_count`=2 (0 with macro off); `halt_cpu` stays 0.
- ARBITRARY_HALT=1 with the buffer empty → `halt_cpu`=1 next cycle. Write 0 → `halt_cpu`=0 next cycle.
- `rst_n` pulsed low with 3 beats queued and `tready`=0 → `tvalid` drops to 0 asynchronously; after release, no stale beats appear and `pkt_cnt` restarts.
